// File: rtl/srrc_tx_flt.sv
// ---------------------------------------------------------------------------
// srrc_tx_flt
//
// Transmit-side square-root raised-cosine pulse-shaping interpolator with
// 4 samples per symbol. A 5-deep symbol delay line feeds a 4-phase
// polyphase decomposition of the 17-tap symmetric SRRC response. One 1s17
// symbol is taken per 4 sample strobes and one shaped 1s17 sample is
// produced on every strobe.
//
// Optional build macro: SRRC_TX_PIPE_EN
//   Defined   - the per-phase product terms are registered at the strobe
//               edge. The adder tree and saturation load `out` one clk later,
//               and out_valid pulses on that later edge.
//   Undefined - the products, adder tree and saturation are combinational
//               from the delay line into the `out` register.
//   The sample values are the same in both builds.
//
// Parameters:
//   ACC_W      adder-tree width (>= 20); the sum saturates to 18 bits
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset (clears all state when 0)
//   sam_clk    sample-rate enable, one output sample per strobe
//   in         signed 1s17 input symbol
//   in_valid   `in` holds a valid symbol
//   in_ready   registered; high for the whole phase-3 interval
//   out        signed 1s17 shaped output sample
//   out_valid  one-clk pulse on each `out` update
//   sym_phase  current polyphase index 0..3
//   underrun   sticky; a symbol slot passed with no valid symbol
// ---------------------------------------------------------------------------
module srrc_tx_flt #(
  parameter int ACC_W = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sam_clk,
  input  logic [17:0] in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [17:0] out,
  output logic        out_valid,
  output logic [1:0]  sym_phase,
  output logic        underrun
);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(131071);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-131072);

  // Only b0..b8 are stored; the upper half of the response mirrors them.
  // Taps past the end of the response (phases 1..3 of the oldest symbol)
  // contribute nothing.
  function automatic logic signed [17:0] tap_coef(input logic [4:0] k);
    logic [4:0] m;
    m = (k > 5'd8) ? (5'd16 - k) : k;
    if (k > 5'd16) begin
      tap_coef = '0;
    end else begin
      case (m)
        5'd0:    tap_coef = 18'sd3259;
        5'd1:    tap_coef = -18'sd3378;
        5'd2:    tap_coef = -18'sd10461;
        5'd3:    tap_coef = -18'sd12207;
        5'd4:    tap_coef = -18'sd3946;
        5'd5:    tap_coef = 18'sd14611;
        5'd6:    tap_coef = 18'sd38196;
        5'd7:    tap_coef = 18'sd57937;
        5'd8:    tap_coef = 18'sd65624;
        default: tap_coef = '0;
      endcase
    end
  endfunction

  logic signed [17:0] s [5];
  logic signed [35:0] prod [5];
  logic signed [17:0] term [5];
  logic signed [17:0] sum_in [5];
  logic signed [ACC_W-1:0] acc;
  logic [17:0] y;
  logic load_out;
  logic slot;

  assign slot = sam_clk && (sym_phase == 2'd3);

  // Phase counter and in_ready. in_ready is registered so it is already high
  // during the whole phase-3 interval, ahead of the slot edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_phase <= 2'd0;
      in_ready  <= 1'b0;
    end else if (sam_clk) begin
      sym_phase <= sym_phase + 2'd1;
      in_ready  <= (sym_phase == 2'd2);
    end
  end

  // Symbol delay line. Every slot shifts; a missing symbol is replaced by
  // zero so the pulse train keeps its timing, and the miss is latched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < 5; j++) s[j] <= '0;
      underrun <= 1'b0;
    end else if (slot) begin
      for (int j = 1; j < 5; j++) s[j] <= s[j-1];
      if (in_valid) begin
        s[0] <= $signed(in);
      end else begin
        s[0]     <= '0;
        underrun <= 1'b1;
      end
    end
  end

  // Polyphase products: symbol j meets tap 4j+p. Keeping product[34:17]
  // is an arithmetic shift by 17 with floor rounding.
  always_comb begin
    for (int j = 0; j < 5; j++) begin
      prod[j] = s[j] * tap_coef(5'(4 * j) + {3'b000, sym_phase});
      term[j] = 18'(prod[j] >>> 17);
    end
  end

`ifdef SRRC_TX_PIPE_EN
  logic signed [17:0] term_q [5];
  logic term_vld;

  // Product terms are captured on the strobe; the sum lands one clk later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < 5; j++) term_q[j] <= '0;
      term_vld <= 1'b0;
    end else begin
      term_vld <= sam_clk;
      if (sam_clk) begin
        for (int j = 0; j < 5; j++) term_q[j] <= term[j];
      end
    end
  end

  assign sum_in   = term_q;
  assign load_out = term_vld;
`else
  assign sum_in   = term;
  assign load_out = sam_clk;
`endif

  // Adder tree with saturation back to 1s17.
  always_comb begin
    acc = '0;
    y   = '0;
    for (int j = 0; j < 5; j++) begin
      acc = acc + {{(ACC_W-18){sum_in[j][17]}}, sum_in[j]};
    end
    if (acc > SAT_HI) begin
      y = 18'h1FFFF;
    end else if (acc < SAT_LO) begin
      y = 18'h20000;
    end else begin
      y = acc[17:0];
    end
  end

  // Output register and its one-clk valid pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= load_out;
      if (load_out) out <= y;
    end
  end

endmodule

// File: tb/tb_srrc_tx_flt.sv
// ---------------------------------------------------------------------------
// tb_srrc_tx_flt
//
// Directed testbench for srrc_tx_flt: reset state, in_ready timing, impulse
// response, DC steady state, handshake/underrun and sparse strobes, with
// hand-computed expected values. Works for either setting of
// SRRC_TX_PIPE_EN; the expected out_valid position follows the macro.
// ---------------------------------------------------------------------------
module tb_srrc_tx_flt;

`ifdef SRRC_TX_PIPE_EN
  localparam int PIPE_LAT = 1;
`else
  localparam int PIPE_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sam_clk = 1'b0;
  logic [17:0] sym_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] out;
  logic        out_valid;
  logic [1:0]  sym_phase;
  logic        underrun;

  int total = 0;
  int bad = 0;
  int cap_q [$];
  int valid_count = 0;
  int bench_phase = 0;
  int hb [9] = '{3259, -3378, -10461, -12207, -3946, 14611, 38196, 57937, 65624};
  int dc_exp [4] = '{32124, 28480, 27734, 28480};

  srrc_tx_flt #(.ACC_W(21)) dut (
    .clk       (clk),
    .reset     (reset),
    .sam_clk   (sam_clk),
    .in        (sym_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .sym_phase (sym_phase),
    .underrun  (underrun)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Collect every published sample, sampled away from the active edge.
  always @(negedge clk) begin
    if (out_valid) begin
      cap_q.push_back(int'($signed(out)));
      valid_count++;
    end
  end

  function automatic int h_tap(input int k);
    if (k > 16) return 0;
    if (k <= 8) return hb[k];
    return hb[16 - k];
  endfunction

  task automatic checkOutput(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // One sam_clk strobe, then `gap` idle clks. With a gap the out_valid
  // position and the phase hold are checked as well.
  task automatic applyStimulus(input logic v, input logic [17:0] d, input int gap);
    sam_clk  = 1'b1;
    in_valid = v;
    sym_in   = d;
    @(posedge clk); #1;
    sam_clk  = 1'b0;
    in_valid = 1'b0;
    sym_in   = '0;
    bench_phase = (bench_phase + 1) % 4;
    if (gap > 0) begin
      checkOutput("ov_at_strobe", int'(out_valid), 1 - PIPE_LAT);
      @(posedge clk); #1;
      checkOutput("ov_after_strobe", int'(out_valid), PIPE_LAT);
      checkOutput("phase_hold", int'(sym_phase), bench_phase);
      repeat (gap - 1) @(posedge clk);
      #1;
    end
  endtask

  task automatic flushPipe();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_out"}, int'($signed(out)), 0);
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_phase"}, int'(sym_phase), 0);
    checkOutput({tag, "_in_ready"}, int'(in_ready), 0);
    checkOutput({tag, "_underrun"}, int'(underrun), 0);
  endtask

  initial begin
    // Power-on reset.
    #2 reset = 1'b0;
    #10;
    checkResetState("por");
    @(posedge clk); #1;
    reset = 1'b1;
    bench_phase = 0;
    @(posedge clk); #1;

    // in_ready rises after the 3rd strobe and holds while idle.
    applyStimulus(1'b0, 18'd0, 0);
    applyStimulus(1'b0, 18'd0, 0);
    checkOutput("in_ready_e2", int'(in_ready), 0);
    applyStimulus(1'b0, 18'd0, 0);
    checkOutput("in_ready_e3", int'(in_ready), 1);
    checkOutput("phase_e3", int'(sym_phase), 3);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("in_ready_hold", int'(in_ready), 1);
    checkOutput("underrun_no_slot", int'(underrun), 0);

    // Impulse, back-to-back strobes.
    cap_q.delete();
    applyStimulus(1'b1, 18'h20000, 0);
    for (int i = 0; i < 18; i++) applyStimulus(1'b1, 18'd0, 0);
    flushPipe();
    checkOutput("imp_count", cap_q.size(), 19);
    if (cap_q.size() == 19) begin
      for (int k = 1; k <= 18; k++)
        checkOutput($sformatf("imp_E+%0d", k), cap_q[k], -h_tap(k - 1));
    end
    checkOutput("imp_underrun", int'(underrun), 0);

    // DC steady state, starting from phase 2.
    cap_q.delete();
    begin
      int start_phase;
      start_phase = bench_phase;
      for (int i = 0; i < 28; i++) applyStimulus(1'b1, 18'd65536, 0);
      flushPipe();
      checkOutput("dc_count", cap_q.size(), 28);
      if (cap_q.size() == 28) begin
        for (int i = 20; i < 28; i++)
          checkOutput($sformatf("dc_p%0d", (start_phase + i) % 4),
                      cap_q[i], dc_exp[(start_phase + i) % 4]);
      end
    end

    // Mid-stream asynchronous reset at phase 2 with a nonzero output.
    checkOutput("pre_rst_phase", int'(sym_phase), 2);
    checkOutput("pre_rst_out", int'($signed(out)), 28480);
    #3 reset = 1'b0;
    #1;
    checkResetState("mid");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    bench_phase = 0;

    // Handshake: valid only in phase 0, never accepted.
    cap_q.delete();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(bench_phase == 0, 18'd50000, 0);
      if (i == 2) checkOutput("hs_underrun_pre", int'(underrun), 0);
      if (i == 3) checkOutput("hs_underrun_set", int'(underrun), 1);
    end
    applyStimulus(1'b0, 18'd0, 0);
    applyStimulus(1'b0, 18'd0, 0);
    applyStimulus(1'b0, 18'd0, 0);
    checkOutput("hs_in_ready", int'(in_ready), 1);
    applyStimulus(1'b1, 18'h20000, 0);
    applyStimulus(1'b0, 18'd0, 0);
    flushPipe();
    checkOutput("hs_count", cap_q.size(), 13);
    if (cap_q.size() == 13) begin
      int nz;
      nz = 0;
      for (int i = 0; i < 12; i++) if (cap_q[i] != 0) nz++;
      checkOutput("hs_no_accept", nz, 0);
      checkOutput("hs_accept", cap_q[12], -3259);
    end
    checkOutput("hs_underrun_sticky", int'(underrun), 1);
    #3 reset = 1'b0;
    #1;
    checkOutput("hs_underrun_clr", int'(underrun), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    bench_phase = 0;
    @(posedge clk); #1;

    // Sparse strobes: one every 3rd clk, impulse again.
    cap_q.delete();
    valid_count = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 18'd0, 2);
    applyStimulus(1'b1, 18'h20000, 2);
    for (int i = 0; i < 18; i++) applyStimulus(1'b1, 18'd0, 2);
    flushPipe();
    checkOutput("sp_pulses", valid_count, 22);
    checkOutput("sp_count", cap_q.size(), 22);
    if (cap_q.size() == 22) begin
      for (int k = 1; k <= 18; k++)
        checkOutput($sformatf("sp_E+%0d", k), cap_q[3 + k], -h_tap(k - 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
